// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, ASCII codes, requester ids.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SEND    = 3'd1;
    localparam state_t ST_WAIT_HI = 3'd2;
    localparam state_t ST_WAIT_LO = 3'd3;
    localparam state_t ST_GAP     = 3'd4;
    localparam state_t ST_LF      = 3'd5;

    typedef enum logic {
        REQ_KB  = 1'b0,
        REQ_AUX = 1'b1
    } req_id_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_fifo.sv
// Keyboard byte FIFO; read data is the head entry, valid combinationally while not empty.
// Latency: a pushed byte is visible at the head one cycle after the push.
// Backpressure: none upstream; a push while full is ignored unless a pop happens in the same cycle.
module kb_byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wr_dat,
    input  logic          pop,
    output logic [7:0]    rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign rd_dat  = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from a keyboard FIFO and an aux requester; TX_CRLF_EN adds LF after keyboard CR.
// Latency: grant to tx_send is 1 cycle; a keyboard byte reaches tx_send 2 cycles after kb_done when idle.
// Backpressure: aux waits on aux_ready; keyboard cannot stall, bytes arriving at a full FIFO are dropped and flagged.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int GUARD_CYCLES = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    kb_data,
    input  logic                          kb_done,
    input  logic [7:0]                    aux_data,
    input  logic                          aux_valid,
    output logic                          aux_ready,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_data,
    output logic                          tx_send,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          kb_overflow,
    output logic                          active
);

    localparam logic [7:0] HI_LAST  = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GUARD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    req_id_t    last_q, last_d;
    logic       ovf_q, ovf_d;
`ifdef TX_CRLF_EN
    logic       src_kb_q, src_kb_d;
`endif

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_dat;
    logic       grant_kb, grant_aux;

    kb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push   (kb_done),
        .wr_dat (kb_data),
        .pop    (fifo_pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        grant_kb  = 1'b0;
        grant_aux = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!fifo_empty && aux_valid) begin
                if (last_q == REQ_AUX) grant_kb  = 1'b1;
                else                   grant_aux = 1'b1;
            end else if (!fifo_empty) begin
                grant_kb = 1'b1;
            end else if (aux_valid) begin
                grant_aux = 1'b1;
            end
        end
    end

    assign fifo_pop    = grant_kb;
    // Gated so the accept pulse cannot leak out while reset is held.
    assign aux_ready   = grant_aux & reset;
    assign tx_send     = (state_q == ST_SEND);
    assign active      = (state_q != ST_IDLE);
    assign tx_data     = tx_data_q;
    assign kb_overflow = ovf_q;
    assign ovf_d       = ovf_q | (kb_done & fifo_full & ~fifo_pop);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
`ifdef TX_CRLF_EN
        src_kb_d  = src_kb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_kb || grant_aux) begin
                    state_d   = ST_SEND;
                    tx_data_d = grant_kb ? fifo_dat : aux_data;
                    last_d    = grant_kb ? REQ_KB : REQ_AUX;
`ifdef TX_CRLF_EN
                    src_kb_d  = grant_kb;
`endif
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_HI;
                cnt_d   = '0;
            end
            ST_WAIT_HI: begin
                if (tx_busy || cnt_q == HI_LAST) state_d = ST_WAIT_LO;
                else                             cnt_d   = cnt_q + 8'd1;
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
`ifdef TX_CRLF_EN
                    state_d = (src_kb_q && tx_data_q == ASCII_CR) ? ST_LF : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef TX_CRLF_EN
            ST_LF: begin
                state_d   = ST_SEND;
                tx_data_d = ASCII_LF;
                src_kb_d  = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            last_q    <= REQ_AUX;
            ovf_q     <= 1'b0;
`ifdef TX_CRLF_EN
            src_kb_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
`ifdef TX_CRLF_EN
            src_kb_q  <= src_kb_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner sequences and random traffic against a queue model.
module tb_uart_tx_arbiter;

    localparam int DEPTH = 8;
    localparam int GUARD = 16;
    localparam int BT    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_done = 1'b0;
    logic [7:0] aux_data = 8'h00;
    logic       aux_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic       aux_ready, tx_send, kb_overflow, active;
    logic [7:0] tx_data;
    logic [3:0] fifo_count;

    uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .GUARD_CYCLES(GUARD), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .reset       (reset),
        .kb_data     (kb_data),
        .kb_done     (kb_done),
        .aux_data    (aux_data),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .fifo_count  (fifo_count),
        .kb_overflow (kb_overflow),
        .active      (active)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic       s_tx_send, s_aux_ready, s_active, s_ovf;
    logic [7:0] s_tx_data;
    logic [3:0] s_cnt;

    // Reference model: keyboard queue, sticky overflow, last grant, expected sends.
    logic [7:0] kbq[$];
    logic [7:0] sent_q[$];
    bit         m_ovf = 0, m_last_kb = 0, exp_vld = 0, lf_pend = 0;
    logic [7:0] exp_dat = 8'h00;

    // Transmitter model: busy window [rise, fall) in cycle numbers.
    int rise = -1, fall = -1;
    bit rand_mode = 0, hold_busy = 0;
    int cfg_d = 1, cfg_len = 1;
    int ready_pulses = 0;

    typedef struct {
        bit         is_aux;
        logic [7:0] dat;
        int         d;
        int         len;
        int         exp_lat;
        int         exp_act;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_cycle();
        bit g_aux;
        int d, len;
        chk("fifo_count", s_cnt, kbq.size());
        chk("kb_overflow", s_ovf, m_ovf);
        if (exp_vld) begin
            chk("tx_send_after_grant", s_tx_send, 1);
            chk("tx_data_granted", s_tx_data, exp_dat);
            exp_vld = 0;
        end else if (s_tx_send && lf_pend) begin
            chk("lf_inserted", s_tx_data, 8'h0A);
            lf_pend = 0;
        end else begin
            chk("tx_send_quiet", s_tx_send, 0);
        end
        if (s_tx_send) begin
            sent_q.push_back(s_tx_data);
            d   = rand_mode ? int'($urandom_range(0, BT)) : cfg_d;
            len = rand_mode ? int'($urandom_range(1, 6)) : cfg_len;
            rise = (d == 0) ? -1 : cyc + d;
            fall = rise + len;
        end
        if (s_aux_ready) ready_pulses++;
        if (!s_active && (kbq.size() > 0 || aux_valid)) begin
            g_aux = aux_valid && (kbq.size() == 0 || m_last_kb);
            chk("aux_ready_grant", s_aux_ready, g_aux);
`ifdef TX_CRLF_EN
            chk("lf_before_grant", lf_pend, 0);
`endif
            if (g_aux) begin
                exp_dat   = aux_data;
                m_last_kb = 0;
            end else begin
                exp_dat   = kbq.pop_front();
                m_last_kb = 1;
`ifdef TX_CRLF_EN
                if (exp_dat == 8'h0D) lf_pend = 1;
`endif
            end
            exp_vld = 1;
        end else begin
            chk("aux_ready_hold", s_aux_ready, 0);
        end
        if (kb_done) begin
            if (kbq.size() < DEPTH) kbq.push_back(kb_data);
            else                    m_ovf = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_tx_send   = tx_send;
        s_aux_ready = aux_ready;
        s_active    = active;
        s_ovf       = kb_overflow;
        s_tx_data   = tx_data;
        s_cnt       = fifo_count;
        if (reset) model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        kb_done = 0;
        if (s_aux_ready && reset) aux_valid = 0;
        tx_busy = hold_busy || (rise >= 0 && cyc >= rise && cyc < fall);
    endtask

    task automatic apply_reset(input int hold);
        reset = 0;
        #1;
        chk("rst_tx_send", tx_send, 0);
        chk("rst_aux_ready", aux_ready, 0);
        chk("rst_active", active, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_kb_overflow", kb_overflow, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        kb_done = 0; aux_valid = 0; hold_busy = 0; tx_busy = 0;
        rise = -1; fall = -1;
        kbq.delete(); sent_q.delete();
        m_ovf = 0; m_last_kb = 0; exp_vld = 0; lf_pend = 0; ready_pulses = 0;
        repeat (hold) @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(k > 2 && !s_active && s_cnt == 0 && !aux_valid && !exp_vld) && k < bound);
        chk("drain_in_bound", k < bound, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, act, sends;

        // {is_aux, data, busy rise delay (0 = never), busy length, send latency, active cycles}
        vt[0] = '{0, 8'h41, 2, 10, 2, 2 + 10 + GUARD + 1};
        vt[1] = '{1, 8'h7A, 1, 3,  1, 1 + 3 + GUARD + 1};
        vt[2] = '{0, 8'h00, 4, 1,  2, 4 + 1 + GUARD + 1};
        vt[3] = '{0, 8'hFF, 0, 0,  2, BT + GUARD + 2};
        vt[4] = '{1, 8'h55, 0, 0,  1, BT + GUARD + 2};
        vt[5] = '{1, 8'h80, 3, 7,  1, 3 + 7 + GUARD + 1};

        #2;
        apply_reset(2);

        for (int i = 0; i < 6; i++) begin
            cfg_d = vt[i].d;
            cfg_len = vt[i].len;
            if (vt[i].is_aux) begin
                aux_valid = 1; aux_data = vt[i].dat;
            end else begin
                kb_done = 1; kb_data = vt[i].dat;
            end
            lat = 0;
            tick();
            while (!s_tx_send && lat < 10) begin
                lat++;
                tick();
            end
            chk("vec_latency", lat, vt[i].exp_lat);
            chk("vec_tx_data", s_tx_data, vt[i].dat);
            act = 0;
            while (s_active && act < 300) begin
                act++;
                tick();
            end
            chk("vec_active_cycles", act, vt[i].exp_act);
        end

        // Three keyboard bytes queued, aux arrives while busy: kb, aux, kb, kb.
        apply_reset(2);
        cfg_d = 1; cfg_len = 2;
        kb_done = 1; kb_data = 8'h11; tick();
        kb_done = 1; kb_data = 8'h22; tick();
        kb_done = 1; kb_data = 8'h33; aux_valid = 1; aux_data = 8'h7A; tick();
        wait_idle(500);
        chk("rr_count", sent_q.size(), 4);
        chk("rr_0", sent_q[0], 8'h11);
        chk("rr_1", sent_q[1], 8'h7A);
        chk("rr_2", sent_q[2], 8'h22);
        chk("rr_3", sent_q[3], 8'h33);
        chk("rr_aux_pulses", ready_pulses, 1);

        // Overflow: transmitter stuck busy while nine keyboard bytes arrive.
        apply_reset(2);
        cfg_d = 1; cfg_len = 1;
        hold_busy = 1; tx_busy = 1;
        aux_valid = 1; aux_data = 8'h99;
        repeat (6) tick();
        for (int i = 0; i < 9; i++) begin
            kb_done = 1; kb_data = 8'(8'h30 + i);
            tick();
        end
        tick();
        chk("ovf_fifo_count", s_cnt, 8);
        chk("ovf_flag", s_ovf, 1);
        hold_busy = 0;
        wait_idle(1000);
        chk("ovf_sent_count", sent_q.size(), 9);
        chk("ovf_first_aux", sent_q[0], 8'h99);
        for (int i = 1; i < 9; i++) chk("ovf_order", sent_q[i], 8'(8'h30 + i - 1));
        chk("ovf_sticky", kb_overflow, 1);

        // Keyboard CR gets an LF only with TX_CRLF_EN; aux CR never does.
        apply_reset(2);
        cfg_d = 1; cfg_len = 1;
        kb_done = 1; kb_data = 8'h0D;
        wait_idle(500);
`ifdef TX_CRLF_EN
        chk("cr_kb_count", sent_q.size(), 2);
        chk("cr_kb_lf", sent_q[1], 8'h0A);
`else
        chk("cr_kb_count", sent_q.size(), 1);
`endif
        chk("cr_kb_byte", sent_q[0], 8'h0D);
        sent_q.delete();
        aux_valid = 1; aux_data = 8'h0D;
        wait_idle(500);
        chk("cr_aux_count", sent_q.size(), 1);
        chk("cr_aux_byte", sent_q[0], 8'h0D);

        // Reset while waiting for busy-low with two bytes queued.
        apply_reset(2);
        hold_busy = 1; tx_busy = 1;
        aux_valid = 1; aux_data = 8'h99;
        repeat (6) tick();
        kb_done = 1; kb_data = 8'hA1; tick();
        kb_done = 1; kb_data = 8'hA2; tick();
        repeat (2) tick();
        chk("pre_reset_count", s_cnt, 2);
        chk("pre_reset_active", s_active, 1);
        apply_reset(3);
        sends = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_tx_send) sends++;
        end
        chk("no_send_after_reset", sends, 0);

        // Random traffic against the model.
        apply_reset(2);
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            kb_done = ($urandom_range(0, 3) == 0);
            kb_data = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
            if (!aux_valid && $urandom_range(0, 9) == 0) begin
                aux_valid = 1;
                aux_data = 8'($urandom);
            end
            tick();
        end
        wait_idle(4000);
        chk("rand_model_empty", kbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, keyboard FIFO entries; SHALL be a power of 2, 2..64.
REQ-002 Parameter GUARD_CYCLES, default 16, idle clk cycles forced between transmitter busy-low and the next send; SHALL be 1..255.
REQ-003 Parameter BUSY_TIMEOUT, default 4, cycles to wait for tx_busy to rise after a send; SHALL be 1..15.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 kb_data  input  8  ASCII byte from keyboard decoder.
REQ-007 kb_done  input  1  one-cycle strobe: kb_data valid; keyboard cannot stall.
REQ-008 aux_data  input  8  byte from second requester.
REQ-009 aux_valid  input  1  aux byte pending; held with aux_data stable until accepted.
REQ-010 aux_ready  output  1  one-cycle accept pulse; transfer when aux_valid & aux_ready.
REQ-011 tx_busy  input  1  transmitter frame in progress.
REQ-012 tx_data  output  8  byte to transmitter, stable from send until next grant.
REQ-013 tx_send  output  1  one-cycle send strobe to transmitter.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current keyboard FIFO occupancy.
REQ-015 kb_overflow  output  1  sticky: keyboard byte dropped.
REQ-016 active  output  1  high whenever state is not IDLE.

Function
REQ-017 kb_done with FIFO not full SHALL write kb_data into FIFO in that cycle; FIFO order SHALL be first-in first-out.
REQ-018 kb_done with FIFO full and no pop in the same cycle SHALL drop the byte and set kb_overflow; write and pop in the same cycle on a full FIFO SHALL accept the byte.
REQ-019 States: IDLE, SEND, WAIT_HI, WAIT_LO, GAP (plus LF under REQ-029).
REQ-020 IDLE: if FIFO non-empty or aux_valid, grant one requester, pop FIFO head or pulse aux_ready, latch byte into tx_data, go SEND next cycle; grant-to-tx_send latency exactly 1 cycle.
REQ-021 Both pending: round-robin, grant the requester not granted last; single pending: granted regardless of history.
REQ-022 SEND: tx_send=1 for exactly one cycle, go WAIT_HI.
REQ-023 WAIT_HI: on tx_busy=1 go WAIT_LO; after BUSY_TIMEOUT cycles without it go WAIT_LO anyway (no deadlock).
REQ-024 WAIT_LO: on tx_busy=0 go GAP.
REQ-025 GAP: count GUARD_CYCLES cycles then go IDLE; no grant before count expires.
REQ-026 Counters SHALL saturate/clear on state entry; no wrap-around effects.

Reset
REQ-027 reset low SHALL immediately force: state IDLE, FIFO empty, fifo_count 0, tx_data 0x00, tx_send 0, aux_ready 0, kb_overflow 0, active 0, last grant = aux (keyboard wins first tie); reset mid-frame SHALL abandon the byte with no further tx_send.

Configuration
REQ-028 Macro TX_CRLF_EN selects automatic line-feed insertion.
REQ-029 Defined: after a keyboard-sourced 0x0D completes GAP, enter LF: tx_data=0x0A, go SEND with no grant, no FIFO pop, no round-robin update; aux 0x0D SHALL not trigger it. Undefined: no LF state, 0x0D sent as-is.

Structure
REQ-030 Shared package SHALL hold state enum, ASCII constants CR=0x0D and LF=0x0A, and requester-id encoding.
REQ-031 Keyboard FIFO SHALL be sub-module kb_byte_fifo (push, pop, data, full, empty, count); arbiter FSM in top.

Verification
REQ-032 kb_done with 0x41, tx_busy high 10 cycles after send -> tx_send one cycle later with tx_data 0x41, next send not before busy-low+16.
REQ-033 FIFO holds 3 bytes and aux_valid 0x7A held -> order kb, aux, kb, kb; aux_ready pulses once.
REQ-034 9 kb_done strobes, tx_busy held high -> fifo_count 8, kb_overflow 1, 9th byte never sent.
REQ-035 tx_busy never rises -> state leaves WAIT_HI after 4 cycles, next byte sent.
REQ-036 TX_CRLF_EN defined, kb 0x0D -> sends 0x0D then 0x0A; aux 0x0D -> only 0x0D; undefined -> only 0x0D.
REQ-037 reset asserted in WAIT_LO with 2 bytes queued -> all outputs at reset values, fifo_count 0, no tx_send after release.
